mem_serial_bridge: RTL

MEM_SERIAL_BRIDGE -- requirements
Module: mem_serial_bridge

---
 rtl/mem_serial_bridge.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_serial_bridge.sv
// Memory-request to narrow serial link bridge.
// Requests are captured and serialised onto the link: writes are posted and go out
// LSB-first, while reads send a single address beat and park their tag in a small FIFO.
// Read data returns MSB-first, is assembled in an accumulator and is presented with
// the oldest outstanding tag.
module mem_serial_bridge #(
    parameter int AddrWidth      = 8,
    parameter int DataWidth      = 32,
    parameter int LinkWidth      = 4,
    parameter int IdWidth        = 1,
    parameter int MaxOutstanding = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [AddrWidth-1:0]   req_addr_i,
    input  logic [DataWidth-1:0]   req_data_i,
    input  logic [DataWidth/8-1:0] req_strb_i,
    input  logic                   req_write_i,
    input  logic [IdWidth-1:0]     req_id_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    output logic [DataWidth-1:0]   rsp_data_o,
    output logic [IdWidth-1:0]     rsp_id_o,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [AddrWidth-1:0]   link_addr_o,
    output logic                   link_write_o,
    output logic [LinkWidth-1:0]   link_data_o,
    output logic                   link_strb_o,
    output logic                   link_valid_o,
    input  logic                   link_ready_i,
    input  logic [LinkWidth-1:0]   link_rsp_data_i,
    input  logic                   link_rsp_valid_i,
    input  logic                   link_rsp_last_i,
    output logic                   link_rsp_ready_o,
    output logic                   unexpected_o
);

    localparam int Beats = DataWidth / LinkWidth;
    localparam int BeatW = (Beats > 1) ? $clog2(Beats) : 1;
    localparam int PtrW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int CntW  = $clog2(MaxOutstanding + 1);
    localparam int StrbW = DataWidth / 8;

    localparam logic REQ_IDLE    = 1'b0;
    localparam logic REQ_SEND    = 1'b1;
    localparam logic RSP_PARTIAL = 1'b0;
    localparam logic RSP_DONE    = 1'b1;

    logic                 req_state_q, req_state_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [DataWidth-1:0] data_q, data_d;
    logic [StrbW-1:0]     strb_q, strb_d;
    logic                 write_q, write_d;
    logic [BeatW-1:0]     beat_q, beat_d;

    logic [IdWidth-1:0]   tag_mem_q [MaxOutstanding];
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]      cnt_q, cnt_d;

    logic                 rsp_state_q, rsp_state_d;
    logic [DataWidth-1:0] acc_q, acc_d;
    logic                 unexpected_q, unexpected_d;

    logic                 push_s, pop_s, fifo_full_s, fifo_empty_s;
    logic                 req_ready_s, link_valid_s, link_strb_s;
    logic [LinkWidth-1:0] link_data_s;
    logic                 rsp_valid_s, link_rsp_ready_s;

    assign fifo_full_s  = (cnt_q == CntW'(MaxOutstanding));
    assign fifo_empty_s = (cnt_q == {CntW{1'b0}});

    // Request FSM: capture a request, then walk the beats out onto the link.
    always_comb begin
        req_state_d  = req_state_q;
        addr_d       = addr_q;
        data_d       = data_q;
        strb_d       = strb_q;
        write_d      = write_q;
        beat_d       = beat_q;
        push_s       = 1'b0;
        req_ready_s  = 1'b0;
        link_valid_s = 1'b0;
        link_data_s  = {LinkWidth{1'b0}};
        link_strb_s  = 1'b0;
        case (req_state_q)
            REQ_IDLE: begin
                // Readiness uses the registered occupancy, so a pop in this
                // cycle cannot open the door for a new request until next cycle.
                req_ready_s = !fifo_full_s;
                if (req_valid_i && req_ready_s) begin
                    addr_d      = req_addr_i;
                    data_d      = req_data_i;
                    strb_d      = req_strb_i;
                    write_d     = req_write_i;
                    beat_d      = {BeatW{1'b0}};
                    push_s      = !req_write_i;
                    req_state_d = REQ_SEND;
                end else begin
                    req_state_d = REQ_IDLE;
                end
            end
            REQ_SEND: begin
                link_valid_s = 1'b1;
                if (write_q) begin
                    link_data_s = LinkWidth'(data_q >> (int'(beat_q) * LinkWidth));
                    link_strb_s = 1'(strb_q >> ((int'(beat_q) * LinkWidth) / 8));
                    if (link_ready_i) begin
                        if (beat_q == BeatW'(Beats - 1)) begin
                            beat_d      = {BeatW{1'b0}};
                            req_state_d = REQ_IDLE;
                        end else begin
                            beat_d = beat_q + BeatW'(1);
                        end
                    end else begin
                        beat_d = beat_q;
                    end
                end else begin
                    if (link_ready_i) begin
                        req_state_d = REQ_IDLE;
                    end else begin
                        req_state_d = REQ_SEND;
                    end
                end
            end
            default: begin
                req_state_d = REQ_IDLE;
            end
        endcase
    end

    // Response FSM: assemble returning beats and hand the word out with its tag.
    always_comb begin
        rsp_state_d      = rsp_state_q;
        acc_d            = acc_q;
        unexpected_d     = unexpected_q;
        pop_s            = 1'b0;
        rsp_valid_s      = 1'b0;
        link_rsp_ready_s = 1'b0;
        case (rsp_state_q)
            RSP_PARTIAL: begin
                link_rsp_ready_s = 1'b1;
                if (link_rsp_valid_i) begin
                    if (link_rsp_last_i && fifo_empty_s) begin
                        // Nobody is waiting for this word: drop it and flag it.
                        acc_d        = {DataWidth{1'b0}};
                        unexpected_d = 1'b1;
                    end else if (link_rsp_last_i) begin
                        acc_d       = (acc_q << LinkWidth) | DataWidth'(link_rsp_data_i);
                        rsp_state_d = RSP_DONE;
                    end else begin
                        acc_d = (acc_q << LinkWidth) | DataWidth'(link_rsp_data_i);
                    end
                end else begin
                    acc_d = acc_q;
                end
            end
            RSP_DONE: begin
                rsp_valid_s = 1'b1;
                if (rsp_ready_i) begin
                    pop_s       = 1'b1;
                    acc_d       = {DataWidth{1'b0}};
                    rsp_state_d = RSP_PARTIAL;
                end else begin
                    rsp_state_d = RSP_DONE;
                end
            end
            default: begin
                rsp_state_d = RSP_PARTIAL;
            end
        endcase
    end

    // Tag FIFO pointer and occupancy bookkeeping.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_s) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(MaxOutstanding - 1)) ? {PtrW{1'b0}} : wr_ptr_q + PtrW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(MaxOutstanding - 1)) ? {PtrW{1'b0}} : rd_ptr_q + PtrW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // State, capture, FIFO and flag registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_state_q  <= REQ_IDLE;
            addr_q       <= {AddrWidth{1'b0}};
            data_q       <= {DataWidth{1'b0}};
            strb_q       <= {StrbW{1'b0}};
            write_q      <= 1'b0;
            beat_q       <= {BeatW{1'b0}};
            wr_ptr_q     <= {PtrW{1'b0}};
            rd_ptr_q     <= {PtrW{1'b0}};
            cnt_q        <= {CntW{1'b0}};
            rsp_state_q  <= RSP_PARTIAL;
            acc_q        <= {DataWidth{1'b0}};
            unexpected_q <= 1'b0;
            for (int i = 0; i < MaxOutstanding; i++) begin
                tag_mem_q[i] <= {IdWidth{1'b0}};
            end
        end else begin
            req_state_q  <= req_state_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            strb_q       <= strb_d;
            write_q      <= write_d;
            beat_q       <= beat_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            rsp_state_q  <= rsp_state_d;
            acc_q        <= acc_d;
            unexpected_q <= unexpected_d;
            if (push_s) begin
                tag_mem_q[wr_ptr_q] <= req_id_i;
            end else begin
                tag_mem_q[wr_ptr_q] <= tag_mem_q[wr_ptr_q];
            end
        end
    end

    assign req_ready_o      = req_ready_s;
    assign link_addr_o      = addr_q;
    assign link_write_o     = write_q;
    assign link_data_o      = link_data_s;
    assign link_strb_o      = link_strb_s;
    assign link_valid_o     = link_valid_s;
    assign link_rsp_ready_o = link_rsp_ready_s;
    assign rsp_valid_o      = rsp_valid_s;
    assign rsp_data_o       = acc_q;
    assign rsp_id_o         = tag_mem_q[rd_ptr_q];
    assign unexpected_o     = unexpected_q;

endmodule
